// File: rtl/ipml_prefetch_ctrl_v2_0.sv
// First-word-fall-through prefetch stage between a standard-read FIFO core with a
// configurable read latency and a valid/ready consumer, with skid buffer and flush.
module ipml_prefetch_ctrl_v2_0 #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RAM_LAT    = 1,
  parameter int unsigned SKID_DEPTH = 2,
  localparam int unsigned CNT_W     = $clog2(SKID_DEPTH + 1)
) (
  input  logic              rd_clk,
  input  logic              rd_rst,
  input  logic              flush_i,
  input  logic              fifo_empty_i,
  output logic              fifo_rd_en_o,
  input  logic [DATA_W-1:0] fifo_rd_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [CNT_W-1:0]  skid_cnt_o,
  output logic [CNT_W-1:0]  total_cnt_o
);

  localparam int unsigned PtrW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;

  if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
    $error("RAM_LAT must be in 1..3");
  end
  if (SKID_DEPTH < RAM_LAT + 1) begin : g_bad_depth
    $error("SKID_DEPTH must be at least RAM_LAT+1");
  end

  logic [RAM_LAT-1:0] lat_sr_q, lat_sr_d;
  logic [PtrW-1:0]    rptr_q, rptr_d;
  logic [PtrW-1:0]    wptr_q, wptr_d;
  logic [CNT_W-1:0]   skid_cnt_q, skid_cnt_d;
  logic [CNT_W-1:0]   total_q, total_d;
  logic [DATA_W-1:0]  mem_q [SKID_DEPTH];

  logic               pop;
  logic               wr_en;
  logic               rd_en;
  logic [CNT_W-1:0]   inflight;
  logic [CNT_W:0]     occ_after_pop;

  function automatic logic [CNT_W-1:0] popcnt(input logic [RAM_LAT-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < int'(RAM_LAT); i++) begin
      n = n + CNT_W'(v[i]);
    end
    return n;
  endfunction

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(SKID_DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign pop      = m_valid_o & m_ready_i;
  assign wr_en    = lat_sr_q[RAM_LAT-1];
  assign inflight = popcnt(lat_sr_q);

  // Stored + in-flight never exceeds SKID_DEPTH, so this cannot underflow or wrap.
  assign occ_after_pop = {1'b0, skid_cnt_q} + {1'b0, inflight} - (CNT_W + 1)'(pop);

  assign rd_en = ~fifo_empty_i & ~flush_i & ~rd_rst &
                 (occ_after_pop < (CNT_W + 1)'(SKID_DEPTH));

  always_comb begin
    lat_sr_d   = (lat_sr_q << 1) | RAM_LAT'(rd_en);
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    skid_cnt_d = skid_cnt_q;

    if (pop) begin
      rptr_d = ptr_inc(rptr_q);
    end
    if (wr_en) begin
      wptr_d = ptr_inc(wptr_q);
    end
    case ({wr_en, pop})
      2'b10:   skid_cnt_d = skid_cnt_q + CNT_W'(1);
      2'b01:   skid_cnt_d = skid_cnt_q - CNT_W'(1);
      default: skid_cnt_d = skid_cnt_q;
    endcase

    // Flush drops stored words and every read still travelling through the core.
    if (flush_i) begin
      lat_sr_d   = '0;
      rptr_d     = '0;
      wptr_d     = '0;
      skid_cnt_d = '0;
    end

    total_d = skid_cnt_d + popcnt(lat_sr_d);
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      lat_sr_q   <= '0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      skid_cnt_q <= '0;
      total_q    <= '0;
    end else begin
      lat_sr_q   <= lat_sr_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      skid_cnt_q <= skid_cnt_d;
      total_q    <= total_d;
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      for (int i = 0; i < int'(SKID_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && !flush_i) begin
      mem_q[wptr_q] <= fifo_rd_data_i;
    end
  end

  assign fifo_rd_en_o = rd_en;
  assign m_data_o     = mem_q[rptr_q];
  assign m_valid_o    = (skid_cnt_q != '0);
  assign skid_cnt_o   = skid_cnt_q;
  assign total_cnt_o  = total_q;

endmodule

// File: doc/ipml_prefetch_ctrl_v2_0.md
Name: ipml_prefetch_ctrl_v2_0

Overview:
- Parametrised first-word-fall-through prefetch controller. It sits between a standard-read FIFO core (rd_en in, data after RAM_LAT cycles) and a valid/ready consumer.
- Successor to the fixed 2-entry, latency-1 prefetch stage. Adds configurable RAM read latency, configurable skid depth, a synchronous flush, and occupancy reporting.
- Sustains one word per cycle at any supported latency.

Parameters:
- DATA_W, 32, data width in bits (1..1152).
- RAM_LAT, 1, read latency of the FIFO core in rd_clk cycles from fifo_rd_en to valid fifo_rd_data (1..3).
- SKID_DEPTH, 2, skid buffer entries. Legal only if SKID_DEPTH >= RAM_LAT+1; otherwise elaboration error.
- CNT_W, $clog2(SKID_DEPTH+1), width of the occupancy outputs (derived; do not override).

Ports:
- rd_clk  in  1  read clock.
- rd_rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all prefetched and in-flight words.
- fifo_empty  in  1  FIFO core empty flag.
- fifo_rd_en  out  1  read strobe to the FIFO core. Combinational.
- fifo_rd_data  in  DATA_W  FIFO core read data, valid RAM_LAT cycles after fifo_rd_en.
- m_data  out  DATA_W  head word of the skid buffer.
- m_valid  out  1  m_data valid.
- m_ready  in  1  consumer accepts m_data.
- skid_cnt  out  CNT_W  words stored in the skid buffer.
- total_cnt  out  CNT_W  stored words plus in-flight reads.

Behaviour:
- Reset (rd_rst=1, asynchronous):
  - Skid pointers 0; skid_cnt=0; in-flight shift register all 0.
  - m_valid=0; m_data=0 (storage cleared); total_cnt=0.
  - fifo_rd_en=0 while rd_rst is high.
- pop = m_valid & m_ready.
- Issue logic:
  - inflight = popcount(lat_sr[RAM_LAT-1:0]).
  - fifo_rd_en = ~fifo_empty & ~flush & ~rd_rst & (skid_cnt + inflight - pop < SKID_DEPTH).
- In-flight tracking:
  - lat_sr shifts left each cycle: lat_sr[0] <= fifo_rd_en.
  - When lat_sr[RAM_LAT-1]=1, fifo_rd_data is written into the skid buffer at wptr at the end of that cycle, and wptr increments modulo SKID_DEPTH.
- Skid buffer:
  - Circular, with rptr/wptr wrapping at SKID_DEPTH (not required to be a power of two).
  - m_data = buf[rptr]; m_valid = (skid_cnt != 0).
  - On pop, rptr increments.
  - skid_cnt updates by +write -pop; a simultaneous write and pop leaves it unchanged.
- Ordering: words are delivered in issue order; none are dropped or duplicated, except on flush.
- Latency: fifo_rd_en asserted in cycle t gives m_valid=1 in cycle t+RAM_LAT+1, provided the buffer was empty.
- Throughput: with m_ready held at 1 and the FIFO core non-empty, m_valid stays 1 every cycle after the initial fill.
- Backpressure: with m_ready=0, issue stops once skid_cnt + inflight = SKID_DEPTH. Overflow is impossible by construction.
- Flush (sampled at the rd_clk edge):
  - Pointers, skid_cnt and lat_sr are cleared; m_valid=0 the next cycle.
  - Data returning in that edge's cycle is discarded.
  - fifo_rd_en=0 during the flush cycle.
  - Words already read from the core are lost by design.
  - A pop in the flush cycle is still a legal transfer.
- Empty: once fifo_empty=1, no issue occurs; buffered words still drain normally.
- Reset mid-operation: everything returns to reset values immediately. In-flight data returning after reset release is ignored, because lat_sr=0.
- total_cnt = skid_cnt + inflight, registered view updated every cycle. It never exceeds SKID_DEPTH.
- Assertion for the bench: the number of lat_sr write events per cycle is at most 1, and skid_cnt <= SKID_DEPTH at all times.

Test Plan:
- Basic prefetch:
  - Setup: RAM_LAT=1, SKID_DEPTH=2. Core holds 0xA0..0xA3; fifo_empty falls at cycle 0; m_ready=0.
  - Required: fifo_rd_en high in cycles 0-1, then low. m_valid=1 from cycle 2 with m_data=0xA0. skid_cnt=2 at cycle 3.
- Streaming at latency 3:
  - Setup: RAM_LAT=3, SKID_DEPTH=4, m_ready=1, 16 words 0..15.
  - Required: m_valid high for 16 consecutive cycles starting at cycle 4; data 0..15 in order; no gaps.
- Random backpressure:
  - Setup: RAM_LAT=2, SKID_DEPTH=3, 1000 words, m_ready random at 50%.
  - Required: output sequence equals input sequence, and total_cnt <= 3 always.
- Flush with reads in flight:
  - Setup: RAM_LAT=2. Flush asserted while skid_cnt=2 and inflight=1.
  - Required: next cycle m_valid=0, skid_cnt=0, total_cnt=0. The in-flight word is not delivered. The next word read comes from the core's current head.
- Empty boundary:
  - Setup: fifo_empty=1 with 1 stored word and m_ready=1.
  - Required: word delivered, m_valid falls, fifo_rd_en stays 0.
- Reset mid-stream:
  - Setup: assert rd_rst asynchronously between clock edges during streaming.
  - Required: m_valid=0 and counts 0 immediately. After release, returning data from pre-reset reads is never output.
